regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writeback requesters
//  (e.g. ALU writeback, memory-load writeback, loader/debug port).
//  - Arbitration: round-robin, with valid/ready handshakes.
//  - Output: one registered write per cycle, driven straight onto the regfile
//    write_en/dest/data inputs.
//  - Writes to R0 are accepted and discarded, because R0 always reads as zero.
//  - Sits between the pipeline writeback stage and the 16x24 regfile.
// PARAMETERS
//  DATA_W  24  width of the register data word
//  ADDR_W  4   register address width (16 registers)
//  NREQ    3   number of requesters, 2..8; requester 0 = port index 0
//  CNT_W   16  width of the wr_count and drop_count statistics counters
// PORTS
//  clk              in   1              rising-edge clock
//  rst              in   1              asynchronous, active-low reset
//  hold             in   1              pipeline stall; 1 = grant nothing this cycle
//  req_valid        in   NREQ           requester i has a write pending
//  req_addr         in   NREQ*ADDR_W    dest of requester i at bits [i*ADDR_W +: ADDR_W]
//  req_data         in   NREQ*DATA_W    data of requester i at bits [i*DATA_W +: DATA_W]
//  req_ready        out  NREQ           one-hot grant; handshake = valid[i] & ready[i]
//  reg_write_en     out  1              regfile write enable (registered)
//  reg_write_dest   out  ADDR_W         regfile write address (registered)
//  reg_write_data   out  DATA_W         regfile write data (registered)
//  last_grant       out  3              index of the most recently granted requester
//  wr_count         out  CNT_W          number of writes issued to the regfile
//  drop_count       out  CNT_W          number of accepted writes to R0 that were discarded
// BEHAVIOUR
//  Reset (rst=0, async)
//  - Clears rr_ptr, reg_write_en, reg_write_dest, reg_write_data, last_grant,
//    wr_count and drop_count to 0.
//  - Any in-flight write is lost.
//  - req_ready is 0 while rst=0.
//  Grant (combinational from req_valid, hold and rr_ptr)
//  - hold=1 -> req_ready = 0.
//  - Otherwise the first i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, ...
//    modulo NREQ, gets req_ready[i]=1. All other ready bits are 0.
//  - req_ready may depend on req_valid. Requesters must not make valid depend
//    on ready.
//  - A requester holds valid/addr/data stable until its handshake completes.
//  On a posedge with a handshake from requester g
//  - rr_ptr <= (g+1) mod NREQ (wraps NREQ-1 -> 0); last_grant <= g.
//  - If addr != 0: reg_write_en <= 1, dest/data <= addr/data of g, wr_count++.
//  - If addr == 0: reg_write_en <= 0, drop_count++; dest/data hold their values.
//  On a posedge with no handshake
//  - reg_write_en <= 0. rr_ptr, dest, data and both counters hold.
//  Latency and throughput
//  - Handshake at edge N -> reg_write_en=1 during cycle N..N+1.
//  - The regfile commits the write at edge N+1.
//  - Throughput: 1 write per cycle. Back-to-back grants need no idle cycle.
//  Boundary conditions
//  - Fairness: with all requesters continuously valid, grants rotate
//    0,1,..,NREQ-1,0; no requester waits more than NREQ-1 cycles.
//  - Same-dest writes in consecutive cycles: issued in grant order, so the
//    later grant's data is what remains in the regfile.
//  - hold asserted mid-stream: a write already latched is still issued the
//    next cycle; no new grant is made while hold=1. rr_ptr is unchanged by hold.
//  - Counters wrap (2^CNT_W - 1) -> 0 with no saturation.
//  - Reset asserted mid-stream: outputs go to 0 immediately, without waiting
//    for a clock edge.
// TESTING
//  1. Reset: hold rst=0 with random valids -> all outputs 0, req_ready=0.
//     Release rst -> first grant goes to the lowest valid index.
//  2. NREQ=3, all valid, addrs 1/2/3, data A/B/C, 6 cycles.
//     -> grants 0,1,2,0,1,2; reg_write_en stays 1; dest sequence 1,2,3,..;
//     wr_count=6.
//  3. Req1 writes addr 0, data 0xABCDE.
//     -> req_ready[1]=1; next cycle reg_write_en=0; drop_count=1; wr_count unchanged.
//  4. Req0 and Req2 both write R5 (0x11111, then 0x22222).
//     -> two consecutive writes to R5 in grant order; a regfile read of R5
//     afterwards returns the later grant's value.
//  5. hold=1 for 3 cycles with all valid -> req_ready=0, reg_write_en=0 after
//     the already-latched write drains. Drop hold -> grant resumes at the
//     held rr_ptr.
//  6. Preload wr_count=0xFFFF (force), issue 1 write -> wr_count=0x0000.
//     Assert rst mid-write -> reg_write_en falls before the next edge.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundles the writeback request bus and the regfile write-port outputs of the
// write arbiter. The arbiter takes the slave side. A pipeline or bench drives
// the requests through the master side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int NREQ   = 3,
    parameter int CNT_W  = 16
);
    logic                     hold;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     reg_write_en;
    logic [ADDR_W-1:0]        reg_write_dest;
    logic [DATA_W-1:0]        reg_write_data;
    logic [2:0]               last_grant;
    logic [CNT_W-1:0]         wr_count;
    logic [CNT_W-1:0]         drop_count;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, reg_write_en, reg_write_dest, reg_write_data,
               last_grant, wr_count, drop_count
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, reg_write_en, reg_write_dest, reg_write_data,
               last_grant, wr_count, drop_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single regfile write port among NREQ
// writeback requesters. The grant is combinational and the regfile write is
// registered, so the arbiter issues one write per cycle. The arbiter accepts
// writes to R0 and discards them.
module regfile_write_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int NREQ   = 3,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   rst,    // active-low, asynchronous
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_write_dest;
    logic [DATA_W-1:0] r_write_data;
    logic [2:0]        r_last_grant;
    logic [CNT_W-1:0]  r_wr_count;
    logic [CNT_W-1:0]  r_drop_count;

    logic [NREQ-1:0]   w_ready;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_hs;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [PTR_W-1:0]  w_next_ptr;

    // Grant: pick the first valid requester at or after rr_ptr. The scan runs
    // from the farthest slot down to the nearest, so the nearest match is the
    // last assignment and wins. This removes the need for a found flag.
    always_comb begin
        int idx;
        w_ready   = '0;
        w_gnt_idx = '0;
        w_hs      = 1'b0;
        idx       = 0;
        if (rst && !bus.hold) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (bus.req_valid[idx]) begin
                    w_gnt_idx = PTR_W'(idx);
                    w_hs      = 1'b1;
                end
            end
        end
        w_ready[w_gnt_idx] = w_hs;
    end

    // Mux out the granted requester's payload and the next pointer position
    always_comb begin
        w_sel_addr = bus.req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
        w_sel_data = bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
        w_next_ptr = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + PTR_W'(1);
    end

    // Register the write. An R0 write counts as a drop and leaves dest/data
    // untouched. With no handshake, only the write enable falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr     <= '0;
            r_write_en   <= 1'b0;
            r_write_dest <= '0;
            r_write_data <= '0;
            r_last_grant <= '0;
            r_wr_count   <= '0;
            r_drop_count <= '0;
        end else if (w_hs) begin
            r_rr_ptr     <= w_next_ptr;
            r_last_grant <= 3'(w_gnt_idx);
            if (w_sel_addr != '0) begin
                r_write_en   <= 1'b1;
                r_write_dest <= w_sel_addr;
                r_write_data <= w_sel_data;
                r_wr_count   <= r_wr_count + CNT_W'(1);
            end else begin
                r_write_en   <= 1'b0;
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end else begin
            r_write_en <= 1'b0;
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.reg_write_en   = r_write_en;
    assign bus.reg_write_dest = r_write_dest;
    assign bus.reg_write_data = r_write_data;
    assign bus.last_grant     = r_last_grant;
    assign bus.wr_count       = r_wr_count;
    assign bus.drop_count     = r_drop_count;
endmodule
